// File: rtl/audio_rec_pkg.sv
// rtl/audio_rec_pkg.sv - shared types and constants for the audio capture path
package audio_rec_pkg;
    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT_READY,
        C_ACK,
        C_WAIT_DROP
    } capture_state_t;

    typedef enum logic {
        W_IDLE,
        W_REQ
    } write_state_t;
endpackage

// File: rtl/rec_mono_sat.sv
// rtl/rec_mono_sat.sv - combinational L/R mono mix, gain and 16-bit saturation
module rec_mono_sat
    import audio_rec_pkg::*;
#(
    parameter int GAIN_SHIFT = 6
) (
    input  logic [SAMPLE_W-1:0] left,
    input  logic [SAMPLE_W-1:0] right,
    output logic [SAMPLE_W-1:0] mono
);
    localparam int WW = SAMPLE_W + 1 + GAIN_SHIFT;

    logic signed [SAMPLE_W:0] sum;
    logic signed [WW-1:0]     wide;
    logic                     in_range;

    always_comb begin
        sum  = $signed({left[SAMPLE_W-1], left}) + $signed({right[SAMPLE_W-1], right});
        wide = WW'(sum >>> 1);
        wide = wide <<< GAIN_SHIFT;
        // Fits in 16 bits only when every bit above bit 14 matches the sign.
        in_range = (wide[WW-1:SAMPLE_W-1] == {(WW-SAMPLE_W+1){wide[WW-1]}});
        mono = in_range ? wide[SAMPLE_W-1:0] : (wide[WW-1] ? SAT_MIN : SAT_MAX);
    end
endmodule

// File: rtl/audio_recorder.sv
// rtl/audio_recorder.sv - codec capture, mono pack and Avalon-MM write master; REC_WRAP_EN enables circular buffer
module audio_recorder
    import audio_rec_pkg::*;
#(
    parameter int ADDR_W      = 23,
    parameter int DEPTH_WORDS = 'h100000,
    parameter int GAIN_SHIFT  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              read_ready,
    input  logic [15:0]       readdata_left,
    input  logic [15:0]       readdata_right,
    output logic              read_s,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    input  logic              mem_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              overrun
);
`ifdef REC_WRAP_EN
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH_WORDS - 1);
`else
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_WORDS);
`endif

    capture_state_t      cap_q, cap_d;
    write_state_t        wr_q, wr_d;
    logic [15:0]         l_q, l_d, r_q, r_d, hi_q, hi_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, addr_next;
    logic                samp_vld_q, samp_vld_d, half_q, half_d, valid_q, valid_d;
    logic                busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
    logic                stopping_q, stopping_d, accept;
    logic [15:0]         mono;

    rec_mono_sat #(.GAIN_SHIFT(GAIN_SHIFT)) u_mono (
        .left  (l_q),
        .right (r_q),
        .mono  (mono)
    );

    always_comb begin
        cap_d = cap_q;       wr_d = wr_q;         l_d = l_q;           r_d = r_q;
        samp_vld_d = 1'b0;   half_d = half_q;     hi_d = hi_q;         word_d = word_q;
        valid_d = valid_q;   addr_d = addr_q;     busy_d = busy_q;     done_d = done_q;
        overrun_d = overrun_q;                    stopping_d = stopping_q;
        accept = (wr_q == W_REQ) && !mem_waitrequest;
`ifdef REC_WRAP_EN
        addr_next = (addr_q == LAST_A) ? '0 : addr_q + ADDR_W'(1);
`else
        addr_next = addr_q + ADDR_W'(1);
`endif
        case (cap_q)
            C_WAIT_READY: if (read_ready) cap_d = C_ACK;
            C_ACK: begin
                l_d        = readdata_left;
                r_d        = readdata_right;
                samp_vld_d = 1'b1;
                cap_d      = C_WAIT_DROP;
            end
            C_WAIT_DROP:  if (!read_ready) cap_d = C_WAIT_READY;
            default:      cap_d = C_IDLE;
        endcase
        // A sample already in C_ACK is still registered; only further captures stop.
        if (stop && busy_q) begin
            stopping_d = 1'b1;
            cap_d      = C_IDLE;
        end

        if (wr_q == W_IDLE) begin
            if (valid_q) wr_d = W_REQ;
        end else if (accept) begin
            wr_d    = W_IDLE;
            valid_d = 1'b0;
            addr_d  = addr_next;
        end

        if (samp_vld_q) begin
            if (!half_q) begin
                hi_d   = mono;
                half_d = 1'b1;
            end else begin
                half_d = 1'b0;
                if (valid_q && !accept) begin
                    overrun_d = 1'b1;
                end else begin
                    word_d  = {hi_q, mono};
                    valid_d = 1'b1;
                end
            end
        end else if (stopping_q && half_q && !valid_q) begin
            word_d  = {hi_q, 16'h0000};
            valid_d = 1'b1;
            half_d  = 1'b0;
        end

        if (stopping_q && !samp_vld_q && !half_q && !valid_q) begin
            busy_d     = 1'b0;
            done_d     = 1'b1;
            stopping_d = 1'b0;
        end
`ifndef REC_WRAP_EN
        if (accept && (addr_next == DEPTH_A)) begin
            busy_d     = 1'b0;
            done_d     = 1'b1;
            stopping_d = 1'b0;
            cap_d      = C_IDLE;
            half_d     = 1'b0;
            valid_d    = 1'b0;
            samp_vld_d = 1'b0;
        end
`endif
        if (start && !stop && !busy_q) begin
            busy_d     = 1'b1;
            done_d     = 1'b0;
            overrun_d  = 1'b0;
            stopping_d = 1'b0;
            addr_d     = '0;
            half_d     = 1'b0;
            valid_d    = 1'b0;
            cap_d      = C_WAIT_READY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= C_IDLE;     wr_q <= W_IDLE;      l_q <= '0;           r_q <= '0;
            samp_vld_q <= 1'b0;  half_q <= 1'b0;      hi_q <= '0;          word_q <= '0;
            valid_q <= 1'b0;     addr_q <= '0;        busy_q <= 1'b0;      done_q <= 1'b0;
            overrun_q <= 1'b0;   stopping_q <= 1'b0;
        end else begin
            cap_q <= cap_d;      wr_q <= wr_d;        l_q <= l_d;          r_q <= r_d;
            samp_vld_q <= samp_vld_d;                 half_q <= half_d;    hi_q <= hi_d;
            word_q <= word_d;    valid_q <= valid_d;  addr_q <= addr_d;    busy_q <= busy_d;
            done_q <= done_d;    overrun_q <= overrun_d;                   stopping_q <= stopping_d;
        end
    end

    assign read_s         = (cap_q == C_ACK);
    assign mem_write      = (wr_q == W_REQ);
    assign mem_address    = addr_q;
    assign mem_writedata  = word_q;
    assign mem_byteenable = 4'hF;
    assign busy           = busy_q;
    assign done           = done_q;
    assign overrun        = overrun_q;
endmodule
